// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES job sequencer: FSM encoding, mode values, datapath widths.
package aes_ctrl_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 256;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SEND   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/aes_watchdog.sv
// Job watchdog: counter cleared at launch, counts while a job is in flight,
// flags expiry when it reaches TIMEOUT_CYC-1.
module aes_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk_i,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] r_cnt;

    // Counter: clear has priority over counting, otherwise hold.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/aes_job_sequencer.sv
// Sequences one AES core between UART RX, the start button and UART TX:
// shadow key/text registers, one-deep job queue, launch/wait/send FSM and watchdog.
module aes_job_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int AUTO_START  = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic [AES_BLK_W-1:0] text_i,
    input  logic                 text_vld_i,
    input  logic [AES_KEY_W-1:0] key_i,
    input  logic                 key_vld_i,
    input  logic                 start_btn_i,
    input  logic                 mode_i,
    input  logic                 aes_ready_i,
    input  logic                 aes_done_i,
    input  logic [AES_BLK_W-1:0] aes_result_i,
    input  logic                 tx_busy_i,
    output logic [AES_KEY_W-1:0] aes_key_o,
    output logic [AES_BLK_W-1:0] aes_text_o,
    output logic                 aes_mode_o,
    output logic                 aes_start_o,
    output logic [AES_BLK_W-1:0] result_o,
    output logic                 tx_start_o,
    output logic                 busy_o,
    output logic                 key_loaded_o,
    output logic                 err_o
);

    localparam logic AUTO_EN = (AUTO_START != 0);

    seq_state_e           r_state;
    seq_state_e           w_next;
    logic [AES_KEY_W-1:0] r_aes_key;
    logic [AES_BLK_W-1:0] r_aes_text;
    logic [AES_KEY_W-1:0] r_pend_key;
    logic [AES_BLK_W-1:0] r_pend_text;
    logic                 r_pend_key_vld;
    logic                 r_pend_text_vld;
    logic                 r_aes_mode;
    logic                 r_aes_start;
    logic [AES_BLK_W-1:0] r_result;
    logic                 r_tx_start;
    logic                 r_key_loaded;
    logic                 r_err;
    logic                 r_pending;

    logic w_in_job;
    logic w_req;
    logic w_drop;
    logic w_launch_go;
    logic w_done_ok;
    logic w_expire;
    logic w_timeout;

    assign w_in_job    = (r_state != ST_IDLE);
    assign w_req       = start_btn_i | (AUTO_EN & text_vld_i);
    assign w_drop      = w_req & (~r_key_loaded | r_pending);
    assign w_launch_go = (r_state == ST_IDLE) && (w_next == ST_LAUNCH);
    assign w_done_ok   = (r_state == ST_WAIT) && aes_done_i;
    assign w_timeout   = (r_state == ST_WAIT) && !aes_done_i && w_expire;

    aes_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst      (rst),
        .i_clr    (w_launch_go),
        .i_en     ((r_state == ST_LAUNCH) || (r_state == ST_WAIT)),
        .o_expire (w_expire)
    );

    // Next-state logic; done in the expiry cycle wins over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pending && aes_ready_i) w_next = ST_LAUNCH;
                else                          w_next = ST_IDLE;
            end
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                if (aes_done_i)    w_next = ST_SEND;
                else if (w_expire) w_next = ST_IDLE;
                else               w_next = ST_WAIT;
            end
            ST_SEND: begin
                if (r_tx_start) w_next = ST_IDLE;
                else            w_next = ST_SEND;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Key shadow: direct load when idle, otherwise park in pend_key until the job ends.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_aes_key      <= '0;
            r_pend_key     <= '0;
            r_pend_key_vld <= 1'b0;
            r_key_loaded   <= 1'b0;
        end else begin
            r_key_loaded <= r_key_loaded | key_vld_i;
            if (w_in_job) begin
                if (key_vld_i) begin
                    r_pend_key     <= key_i;
                    r_pend_key_vld <= 1'b1;
                end
            end else begin
                r_pend_key_vld <= 1'b0;
                if (key_vld_i)           r_aes_key <= key_i;
                else if (r_pend_key_vld) r_aes_key <= r_pend_key;
            end
        end
    end

    // Text shadow: same park-and-apply scheme as the key.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_aes_text      <= '0;
            r_pend_text     <= '0;
            r_pend_text_vld <= 1'b0;
        end else begin
            if (w_in_job) begin
                if (text_vld_i) begin
                    r_pend_text     <= text_i;
                    r_pend_text_vld <= 1'b1;
                end
            end else begin
                r_pend_text_vld <= 1'b0;
                if (text_vld_i)           r_aes_text <= text_i;
                else if (r_pend_text_vld) r_aes_text <= r_pend_text;
            end
        end
    end

    // One-deep job queue and sticky error flag.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == ST_LAUNCH)  r_pending <= 1'b0;
            else if (w_req && !w_drop) r_pending <= 1'b1;

            if (w_timeout || w_drop) r_err <= 1'b1;
            else if (w_done_ok)      r_err <= 1'b0;
        end
    end

    // Core handshake: mode frozen at launch, single start pulse, result capture.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_aes_mode  <= MODE_ENC;
            r_aes_start <= 1'b0;
            r_result    <= '0;
        end else begin
            r_aes_start <= w_launch_go;
            if (w_launch_go) r_aes_mode <= mode_i;
            if (w_done_ok)   r_result   <= aes_result_i;
        end
    end

    // TX request: fire at done if TX is idle, else the cycle after TX releases; never twice.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_tx_start <= 1'b0;
        end else if (w_done_ok) begin
            r_tx_start <= ~tx_busy_i;
        end else if ((r_state == ST_SEND) && !r_tx_start && !tx_busy_i) begin
            r_tx_start <= 1'b1;
        end else begin
            r_tx_start <= 1'b0;
        end
    end

    assign aes_key_o    = r_aes_key;
    assign aes_text_o   = r_aes_text;
    assign aes_mode_o   = r_aes_mode;
    assign aes_start_o  = r_aes_start;
    assign result_o     = r_result;
    assign tx_start_o   = r_tx_start;
    assign busy_o       = w_in_job;
    assign key_loaded_o = r_key_loaded;
    assign err_o        = r_err;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer: AES core and UART TX are driven by hand.
module tb_aes_job_sequencer;

    localparam int TO = 32;

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB = 256'h0f0e0d0c0b0a090807060504030201001f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] T2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] R1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] R2 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] R3 = 128'h55555555666666667777777788888888;
    localparam logic [127:0] R4 = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
    localparam logic [127:0] R5 = 128'hddddddddeeeeeeeeffffffff00000000;

    logic         clk_i = 1'b0;
    logic         rst   = 1'b1;
    logic [127:0] text_i = '0;
    logic         text_vld_i = 1'b0;
    logic [255:0] key_i = '0;
    logic         key_vld_i = 1'b0;
    logic         start_btn_i = 1'b0;
    logic         mode_i = 1'b0;
    logic         aes_ready_i = 1'b1;
    logic         aes_done_i = 1'b0;
    logic [127:0] aes_result_i = '0;
    logic         tx_busy_i = 1'b0;
    logic [255:0] aes_key_o;
    logic [127:0] aes_text_o;
    logic         aes_mode_o;
    logic         aes_start_o;
    logic [127:0] result_o;
    logic         tx_start_o;
    logic         busy_o;
    logic         key_loaded_o;
    logic         err_o;

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    int n_tx = 0;
    int s0;
    int tx0;

    aes_job_sequencer #(
        .AUTO_START  (1),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .text_i       (text_i),
        .text_vld_i   (text_vld_i),
        .key_i        (key_i),
        .key_vld_i    (key_vld_i),
        .start_btn_i  (start_btn_i),
        .mode_i       (mode_i),
        .aes_ready_i  (aes_ready_i),
        .aes_done_i   (aes_done_i),
        .aes_result_i (aes_result_i),
        .tx_busy_i    (tx_busy_i),
        .aes_key_o    (aes_key_o),
        .aes_text_o   (aes_text_o),
        .aes_mode_o   (aes_mode_o),
        .aes_start_o  (aes_start_o),
        .result_o     (result_o),
        .tx_start_o   (tx_start_o),
        .busy_o       (busy_o),
        .key_loaded_o (key_loaded_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters for start and TX requests.
    always @(posedge clk_i) begin
        if (aes_start_o) n_start <= n_start + 1;
        if (tx_start_o)  n_tx    <= n_tx + 1;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic done_pulse(input logic [127:0] r);
        aes_done_i   = 1'b1;
        aes_result_i = r;
        step();
        aes_done_i   = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        chk("rst_busy", busy_o, 0);
        chk("rst_key", aes_key_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_kl_err", {key_loaded_o, err_o, aes_start_o, tx_start_o}, 0);
        rst = 1'b0;
        step();

        // 1: key then text auto-starts one job
        key_i = K1; key_vld_i = 1'b1; step(); key_vld_i = 1'b0;
        chk("t1_key", aes_key_o, K1);
        chk("t1_kl", key_loaded_o, 1);
        s0 = n_start; tx0 = n_tx;
        text_i = T1; text_vld_i = 1'b1; mode_i = 1'b0; step(); text_vld_i = 1'b0;
        chk("t1_text", aes_text_o, T1);
        chk("t1_nostart_yet", aes_start_o, 0);
        step();
        chk("t1_start", aes_start_o, 1);
        chk("t1_mode", aes_mode_o, 0);
        chk("t1_busy", busy_o, 1);
        step();
        chk("t1_start_1cyc", aes_start_o, 0);
        repeat (3) step();
        done_pulse(R1);
        chk("t1_result", result_o, R1);
        chk("t1_tx", tx_start_o, 1);
        step();
        chk("t1_tx_1cyc", tx_start_o, 0);
        chk("t1_idle", busy_o, 0);
        chk("t1_nstart", n_start - s0, 1);
        chk("t1_ntx", n_tx - tx0, 1);

        // 2: text before any key is dropped with an error
        rst = 1'b1; step(); rst = 1'b0; step();
        chk("t2_kl0", key_loaded_o, 0);
        s0 = n_start;
        text_i = T1; text_vld_i = 1'b1; step(); text_vld_i = 1'b0;
        chk("t2_err", err_o, 1);
        chk("t2_kl", key_loaded_o, 0);
        repeat (4) step();
        chk("t2_nostart", n_start - s0, 0);
        chk("t2_idle", busy_o, 0);
        key_i = K1; key_vld_i = 1'b1; step(); key_vld_i = 1'b0;
        start_btn_i = 1'b1; step(); start_btn_i = 1'b0;
        step();
        chk("t2_start", aes_start_o, 1);
        chk("t2_err_held", err_o, 1);
        step(); step();
        done_pulse(R2);
        chk("t2_err_clr", err_o, 0);
        chk("t2_result", result_o, R2);
        step();

        // 3: key B arrives mid-job; queued second job uses it
        text_i = T2; text_vld_i = 1'b1; step(); text_vld_i = 1'b0;
        step();
        chk("t3_text", aes_text_o, T2);
        step();
        key_i = KB; key_vld_i = 1'b1; step(); key_vld_i = 1'b0;
        chk("t3_keyA_held", aes_key_o, K1);
        start_btn_i = 1'b1; step(); start_btn_i = 1'b0;
        chk("t3_queue_noerr", err_o, 0);
        step();
        done_pulse(R3);
        chk("t3_keyA_send", aes_key_o, K1);
        step();
        step();
        chk("t3_keyB", aes_key_o, KB);
        chk("t3_start2", aes_start_o, 1);
        step(); step();
        done_pulse(R4);
        chk("t3_result2", result_o, R4);
        step();

        // 4: watchdog expiry
        tx0 = n_tx;
        start_btn_i = 1'b1; step(); start_btn_i = 1'b0;
        step();
        chk("t4_start", aes_start_o, 1);
        repeat (TO - 1) step();
        chk("t4_err_before", err_o, 0);
        chk("t4_busy_before", busy_o, 1);
        step();
        chk("t4_err", err_o, 1);
        chk("t4_busy", busy_o, 0);
        chk("t4_result", result_o, R4);
        chk("t4_ntx", n_tx - tx0, 0);

        // 5: TX busy for 50 cycles at done
        tx0 = n_tx;
        start_btn_i = 1'b1; step(); start_btn_i = 1'b0;
        step(); step();
        tx_busy_i = 1'b1;
        done_pulse(R5);
        chk("t5_tx_held", tx_start_o, 0);
        chk("t5_err_clr", err_o, 0);
        chk("t5_result", result_o, R5);
        repeat (49) step();
        chk("t5_send_busy", busy_o, 1);
        chk("t5_ntx_held", n_tx - tx0, 0);
        tx_busy_i = 1'b0;
        step();
        chk("t5_tx", tx_start_o, 1);
        step();
        chk("t5_tx_1cyc", tx_start_o, 0);
        chk("t5_idle", busy_o, 0);
        chk("t5_ntx", n_tx - tx0, 1);

        // 6: asynchronous reset during WAIT
        start_btn_i = 1'b1; step(); start_btn_i = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_key", aes_key_o, 0);
        chk("t6_text", aes_text_o, 0);
        chk("t6_result", result_o, 0);
        chk("t6_flags", {key_loaded_o, err_o, aes_mode_o, aes_start_o, tx_start_o}, 0);
        step(); rst = 1'b0; step();
        tx0 = n_tx;
        done_pulse(R1);
        chk("t6_done_ign", result_o, 0);
        chk("t6_idle", busy_o, 0);
        step();
        chk("t6_ntx", n_tx - tx0, 0);

        // 7: simultaneous key/text/start, decrypt mode, done in the expiry cycle
        key_i = K1; key_vld_i = 1'b1; step(); key_vld_i = 1'b0;
        s0 = n_start;
        key_i = KB; text_i = T2; mode_i = 1'b1;
        key_vld_i = 1'b1; text_vld_i = 1'b1; start_btn_i = 1'b1;
        step();
        key_vld_i = 1'b0; text_vld_i = 1'b0; start_btn_i = 1'b0;
        chk("t7_key", aes_key_o, KB);
        chk("t7_text", aes_text_o, T2);
        chk("t7_noerr", err_o, 0);
        step();
        chk("t7_start", aes_start_o, 1);
        chk("t7_mode", aes_mode_o, 1);
        mode_i = 1'b0;
        repeat (TO - 1) step();
        chk("t7_busy_last", busy_o, 1);
        done_pulse(R1);
        chk("t7_done_noerr", err_o, 0);
        chk("t7_result", result_o, R1);
        chk("t7_tx", tx_start_o, 1);
        chk("t7_mode_frozen", aes_mode_o, 1);
        step();
        chk("t7_nstart", n_start - s0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
